// File: rtl/controle_vidas_pkg.sv
// Shared definitions for the life-counter block: state encodings, widths,
// starting-life limits and the starting-life decode helper.
package controle_vidas_pkg;

  localparam int unsigned VIDAS_W   = 3;
  localparam int unsigned VIDAS_MAX = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned ESTADO_W  = 3;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO = 3'd0,
    ATIVO  = 3'd1,
    PERDE  = 3'd2,
    REPOS  = 3'd3,
    FIM    = 3'd4,
    INVUL  = 3'd5
  } estado_t;

  // Starting life count is sel+1, saturated at the maximum.
  function automatic logic [VIDAS_W-1:0] vidas_inicial(input logic [SEL_W-1:0] sel);
    logic [VIDAS_W-1:0] v;
    v = VIDAS_W'(sel) + VIDAS_W'(1);
    if (v > VIDAS_W'(VIDAS_MAX)) v = VIDAS_W'(VIDAS_MAX);
    return v;
  endfunction

endpackage

// File: rtl/controle_vidas_if.sv
// Game-control <-> life-counter signal bundle.
// master drives zera/carrega/vidas_sel/colisao/tick and observes the status;
// slave (the life counter) drives vidas/sem_vidas/colisao_valida/
// reposiciona/invulneravel/db_estado.
interface controle_vidas_if;
  import controle_vidas_pkg::*;

  logic                zera;
  logic                carrega;
  logic [SEL_W-1:0]    vidas_sel;
  logic                colisao;
  logic                tick;
  logic [VIDAS_W-1:0]  vidas;
  logic                sem_vidas;
  logic                colisao_valida;
  logic                reposiciona;
  logic                invulneravel;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    output zera, carrega, vidas_sel, colisao, tick,
    input  vidas, sem_vidas, colisao_valida, reposiciona, invulneravel, db_estado
  );

  modport slave (
    input  zera, carrega, vidas_sel, colisao, tick,
    output vidas, sem_vidas, colisao_valida, reposiciona, invulneravel, db_estado
  );
endinterface

// File: rtl/controle_vidas_contador_invul.sv
// contador_invul: tick-enabled modulo-MODULO counter timing the
// post-collision invulnerability window.
// Ports: clock, reset (async, active-high), clr (sync clear),
//        en (count enable), fim_c (combinational end-of-count flag).
module contador_invul
  import controle_vidas_pkg::*;
#(
  parameter int unsigned MODULO = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim_c
);

  logic [CNT_W-1:0] cnt_q;

  assign fim_c = (cnt_q == CNT_W'(MODULO - 1));

  // Wraps to zero on the enabled cycle that reaches the terminal count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (fim_c) cnt_q <= '0;
      else       cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/controle_vidas.sv
// controle_vidas: tracks remaining lives for the drone game, charges one
// life per accepted collision, requests a repositioning and optionally
// opens an invulnerability window of T_INVUL ticks.
// Ports: clock, reset (async, active-high), bus (controle_vidas_if.slave):
//   inputs  zera, carrega, vidas_sel, colisao, tick
//   outputs vidas, sem_vidas, colisao_valida, reposiciona, invulneravel, db_estado
// Build option: define CONTROLE_VIDAS_INVUL_EN to include the INVUL state
// and its counter; otherwise REPOS returns straight to ATIVO.
module controle_vidas
  import controle_vidas_pkg::*;
#(
  parameter int unsigned T_INVUL = 50
) (
  input  logic              clock,
  input  logic              reset,
  controle_vidas_if.slave   bus
);

  estado_t            estado_q, estado_d;
  logic [VIDAS_W-1:0] vidas_q, vidas_d;
  logic               sem_vidas_q, colisao_valida_q, reposiciona_q;

`ifdef CONTROLE_VIDAS_INVUL_EN
  logic fim_c;
  logic conta_c;
  logic invulneravel_q;

  assign conta_c = (estado_q == INVUL) && bus.tick;

  contador_invul #(.MODULO(T_INVUL)) u_contador_invul (
    .clock (clock),
    .reset (reset),
    .clr   (bus.zera),
    .en    (conta_c),
    .fim_c (fim_c)
  );

  assign bus.invulneravel = invulneravel_q;
`else
  logic unused_cfg;
  assign unused_cfg       = bus.tick ^ (|CNT_W'(T_INVUL));
  assign bus.invulneravel = 1'b0;
`endif

  // Next-state and life-count logic; zera overrides every state.
  always_comb begin
    estado_d = estado_q;
    vidas_d  = vidas_q;
    if (bus.zera) begin
      estado_d = OCIOSO;
      vidas_d  = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.carrega) begin
            vidas_d  = vidas_inicial(bus.vidas_sel);
            estado_d = ATIVO;
          end
        end
        ATIVO: begin
          if (bus.colisao) estado_d = PERDE;
        end
        PERDE: begin
          // Guarded against underflow even though PERDE is never entered with 0.
          if (vidas_q <= VIDAS_W'(1)) begin
            vidas_d  = '0;
            estado_d = FIM;
          end else begin
            vidas_d  = vidas_q - VIDAS_W'(1);
            estado_d = REPOS;
          end
        end
        REPOS: begin
`ifdef CONTROLE_VIDAS_INVUL_EN
          estado_d = INVUL;
`else
          estado_d = ATIVO;
`endif
        end
`ifdef CONTROLE_VIDAS_INVUL_EN
        INVUL: begin
          if (bus.tick && fim_c) estado_d = ATIVO;
        end
`endif
        FIM: begin
          vidas_d = '0;
          if (bus.carrega) begin
            vidas_d  = vidas_inicial(bus.vidas_sel);
            estado_d = ATIVO;
          end
        end
        default: begin
          estado_d = OCIOSO;
          vidas_d  = '0;
        end
      endcase
    end
  end

  // State, lives and status flags; flags are registered from the next state
  // so they line up exactly with the registered state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      vidas_q          <= '0;
      sem_vidas_q      <= 1'b0;
      colisao_valida_q <= 1'b0;
      reposiciona_q    <= 1'b0;
`ifdef CONTROLE_VIDAS_INVUL_EN
      invulneravel_q   <= 1'b0;
`endif
    end else begin
      estado_q         <= estado_d;
      vidas_q          <= vidas_d;
      sem_vidas_q      <= (estado_d == FIM);
      colisao_valida_q <= (estado_d == PERDE);
      reposiciona_q    <= (estado_d == REPOS);
`ifdef CONTROLE_VIDAS_INVUL_EN
      invulneravel_q   <= (estado_d == INVUL);
`endif
    end
  end

  assign bus.vidas          = vidas_q;
  assign bus.sem_vidas      = sem_vidas_q;
  assign bus.colisao_valida = colisao_valida_q;
  assign bus.reposiciona    = reposiciona_q;
  assign bus.db_estado      = estado_q;

endmodule

// File: doc/controle_vidas.md
CONTROLE_VIDAS -- requirements
Module: controle_vidas

Interface
REQ-001 Parameter: T_INVUL, 50, number of tick pulses in the post-collision invulnerability window (range 1..255).
REQ-002 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: zera  input  1  synchronous clear of lives and FSM.
REQ-005 Port: carrega  input  1  loads the starting life count.
REQ-006 Port: vidas_sel  input  2  starting-life choice; loaded value = vidas_sel+1 (1..4).
REQ-007 Port: colisao  input  1  one-cycle collision report from the game control unit.
REQ-008 Port: tick  input  1  one-cycle time-base enable pulse.
REQ-009 Port: vidas  output  3  remaining lives.
REQ-010 Port: sem_vidas  output  1  high while no lives remain (game over).
REQ-011 Port: colisao_valida  output  1  one-cycle pulse when a collision costs a life.
REQ-012 Port: reposiciona  output  1  one-cycle pulse requesting the drone position be reset.
REQ-013 Port: invulneravel  output  1  high while collisions are ignored.
REQ-014 Port: db_estado  output  3  debug encoding of the current state.

Function
REQ-015 States and db_estado codes SHALL be: OCIOSO=0, ATIVO=1, PERDE=2, REPOS=3, FIM=4, INVUL=5; all other codes SHALL go to OCIOSO.
REQ-016 zera SHALL have top priority in every state: next state OCIOSO, vidas=0, invulnerability counter=0.
REQ-017 OCIOSO: carrega SHALL load vidas=vidas_sel+1 and go to ATIVO in the next cycle; otherwise the FSM stays in OCIOSO.
REQ-018 ATIVO: colisao SHALL go to PERDE; otherwise the FSM stays in ATIVO; carrega SHALL be ignored.
REQ-019 PERDE: for one cycle, colisao_valida=1 and vidas decrements by 1; if vidas was 1, the next state SHALL be FIM, else REPOS.
REQ-020 REPOS: for one cycle, reposciona=1; the next state SHALL be INVUL when the feature is compiled in, else ATIVO.
REQ-021 INVUL: invulneravel=1; the counter SHALL increment on each tick; when tick arrives with the counter at T_INVUL-1, the counter clears and the next state SHALL be ATIVO.
REQ-022 FIM: sem_vidas=1 and vidas=0; carrega SHALL reload per REQ-017 and go to ATIVO.
REQ-023 colisao SHALL be ignored in PERDE, REPOS, INVUL, FIM and OCIOSO; each state SHALL cost at most one life per entry into PERDE.
REQ-024 vidas SHALL never underflow below 0 and never exceed 4.
REQ-025 All outputs SHALL be Moore outputs decoded from the registered state and registers only.

Reset
REQ-026 After reset is asserted: state=OCIOSO, vidas=0, counter=0, and sem_vidas, colisao_valida, reposiciona and invulneravel=0.
REQ-027 Reset asserted mid-INVUL or mid-PERDE SHALL abort immediately, with no pending pulse emitted after release.

Configuration
REQ-028 Macro CONTROLE_VIDAS_INVUL_EN defined: the INVUL state and counter are present per REQ-021.
REQ-029 Macro CONTROLE_VIDAS_INVUL_EN undefined: INVUL and the counter are removed, REPOS goes directly to ATIVO, invulneravel is tied to 0, and T_INVUL is unused.

Structure
REQ-030 A shared package SHALL hold the state encodings, the life-width constant (3) and the maximum starting life count (4).
REQ-031 One sub-module, contador_invul (a tick-enabled modulo-T_INVUL counter with a synchronous clear and an end-of-count flag), SHALL implement the window and be instantiated only under the macro.

Verification
REQ-032 Scenario: reset, then carrega with vidas_sel=2 -> vidas=3 and db_estado=1 one cycle later.
REQ-033 Scenario: vidas=3, one colisao pulse -> colisao_valida, then reposciona on successive cycles; vidas=2; invulneravel held for exactly 50 ticks; then db_estado=1.
REQ-034 Scenario: colisao pulsed during INVUL -> vidas unchanged and no colisao_valida pulse.
REQ-035 Scenario: vidas_sel=0, one colisao -> vidas=0, sem_vidas=1, db_estado=4; then carrega with vidas_sel=3 -> vidas=4 and ATIVO.
REQ-036 Scenario: zera and colisao in the same cycle while ATIVO -> OCIOSO, vidas=0, no colisao_valida pulse.
REQ-037 Scenario: build without the macro, one colisao -> REPOS goes directly to ATIVO one cycle later and invulneravel stays 0 throughout.
